// File: rtl/data_ram_resp.sv
// -----------------------------------------------------------------------------
// data_ram_resp
//   Slave end of the MEM-stage data RAM interface. Holds a word-organised,
//   byte-writable SRAM and services each access after LATENCY wait states.
//   stall_req_o is raised until the access completes. Read data is returned
//   in a one-cycle DONE window, in which the pipeline advances.
//
// Parameters
//   ADDR_W   word-address width, depth = 2**ADDR_W 32-bit words
//   LATENCY  wait-state cycles per access, legal range 1..15
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   mem_ce_i     access request (chip enable)
//   mem_we_i     1 = write, 0 = read
//   mem_addr_i   byte address; word index = mem_addr_i[ADDR_W+1:2]
//   mem_data_i   write data
//   mem_sel_i    byte-lane write enables, sel[3] -> data[31:24] (offset 00)
//   mem_data_o   read data, held until the next completed read
//   stall_req_o  stall request to pipeline control
//   done_o       one-cycle completion pulse
// -----------------------------------------------------------------------------
module data_ram_resp #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic [3:0]  mem_sel_i,
    output logic [31:0] mem_data_o,
    output logic        stall_req_o,
    output logic        done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;

    // Request latched on acceptance; bus changes during BUSY are ignored.
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         data_q;
    logic [3:0]          sel_q;

    logic [31:0]         rdata_q;
    logic [31:0]         mem_q [2**ADDR_W];

    // Access performed on the coming edge, and the request it uses.
    logic                acc_go;
    logic                acc_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [31:0]         acc_data;
    logic [3:0]          acc_sel;

    // Address bits outside the word index are deliberately ignored (aliasing).
    logic                unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every comb output gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (mem_ce_i) begin
                    if (LATENCY == 1) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            BUSY: begin
                if (!mem_ce_i) begin
                    // Pipeline flush: drop the access without touching memory.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            DONE: begin
                // A request still asserted here is the one just completed.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        stall_req_o = ((state_q == IDLE) && mem_ce_i) || (state_q == BUSY);
        done_o      = (state_q == DONE);
        mem_data_o  = rdata_q;
    end

    // -------------------------------------------------------------------------
    // Access select: with LATENCY==1 the access happens on the accepting edge
    // straight from the bus; otherwise it uses the latched request.
    // -------------------------------------------------------------------------
    always_comb begin
        acc_go   = 1'b0;
        acc_we   = we_q;
        acc_addr = addr_q;
        acc_data = data_q;
        acc_sel  = sel_q;
        if ((state_q == IDLE) && mem_ce_i && (LATENCY == 1)) begin
            acc_go   = 1'b1;
            acc_we   = mem_we_i;
            acc_addr = mem_addr_i[ADDR_W+1:2];
            acc_data = mem_data_i;
            acc_sel  = mem_sel_i;
        end else if ((state_q == BUSY) && mem_ce_i && (cnt_q == 4'd1)) begin
            acc_go   = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Request latch and read-data register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
        end else begin
            if ((state_q == IDLE) && mem_ce_i) begin
                we_q   <= mem_we_i;
                addr_q <= mem_addr_i[ADDR_W+1:2];
                data_q <= mem_data_i;
                sel_q  <= mem_sel_i;
            end
            // Reads return the full word; lane extraction is the MEM stage's job.
            if (acc_go && !acc_we) begin
                rdata_q <= mem_q[acc_addr];
            end
        end
    end

    // -------------------------------------------------------------------------
    // SRAM array
    // -------------------------------------------------------------------------
    // NOTE: the memory array has no reset; it is a plain clocked RAM whose
    // contents are undefined until written. The rst_n term only blocks a
    // write from being committed while reset is held.
    always_ff @(posedge clk) begin
        if (acc_go && acc_we && rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_sel[i]) begin
                    mem_q[acc_addr][8*i +: 8] <= acc_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_ram_resp.sv
// -----------------------------------------------------------------------------
// tb_data_ram_resp
//   Self-checking bench for data_ram_resp. Two instances: LATENCY=2 (index 0)
//   and LATENCY=1 (index 1), sharing the address/data bus but each with its
//   own chip enable. A word-array reference model per instance tracks memory
//   contents and the last read value.
// -----------------------------------------------------------------------------
module tb_data_ram_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce2, ce1;
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic [31:0] rd2, rd1;
    logic        st2, st1, dn2, dn1;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    longint      cyc = 0;

    logic [31:0] mdl      [2][1024];
    bit          vld      [2][1024];
    logic [31:0] last_rd  [2];
    longint      last_done[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_ram_resp #(.ADDR_W(10), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .mem_ce_i(ce2), .mem_we_i(we),
        .mem_addr_i(addr), .mem_data_i(wdata), .mem_sel_i(sel),
        .mem_data_o(rd2), .stall_req_o(st2), .done_o(dn2)
    );

    data_ram_resp #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .mem_ce_i(ce1), .mem_we_i(we),
        .mem_addr_i(addr), .mem_data_i(wdata), .mem_sel_i(sel),
        .mem_data_o(rd1), .stall_req_o(st1), .done_o(dn1)
    );

    function automatic logic f_stall(input int w);
        return (w == 0) ? st2 : st1;
    endfunction

    function automatic logic f_done(input int w);
        return (w == 0) ? dn2 : dn1;
    endfunction

    function automatic logic [31:0] f_rdata(input int w);
        return (w == 0) ? rd2 : rd1;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One complete access on instance w. Starts at the next falling edge;
    // returns at the falling edge inside the DONE cycle. keep leaves the
    // chip enable asserted for a back-to-back follow-up; chk_gap checks the
    // spacing from the previous done pulse.
    task automatic access(input int w, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          input bit keep, input bit chk_gap);
        int lat   = (w == 0) ? 2 : 1;
        int waits = 0;
        int idx   = int'(a[11:2]);
        @(negedge clk);
        we = wr; addr = a; wdata = d; sel = s;
        if (w == 0) ce2 = 1'b1; else ce1 = 1'b1;
        #1 check("stall_accept", 32'(f_stall(w)), 32'd1);
        @(negedge clk);
        while (!f_done(w) && waits < 20) begin
            check("stall_busy", 32'(f_stall(w)), 32'd1);
            // Bus activity during the wait states must not affect the access.
            we = 1'($urandom); addr = $urandom; wdata = $urandom; sel = 4'($urandom);
            waits++;
            @(negedge clk);
        end
        check("done_seen", 32'(f_done(w)), 32'd1);
        check("wait_cycles", 32'(waits), 32'(lat - 1));
        check("stall_done", 32'(f_stall(w)), 32'd0);
        if (chk_gap) check("b2b_gap", 32'(cyc - last_done[w]), 32'(lat + 1));
        last_done[w] = cyc;
        if (wr) begin
            check("rd_hold", f_rdata(w), last_rd[w]);
            for (int i = 0; i < 4; i++)
                if (s[i]) mdl[w][idx][8*i +: 8] = d[8*i +: 8];
            vld[w][idx] = 1'b1;
        end else begin
            check("rd_data", f_rdata(w), mdl[w][idx]);
            last_rd[w] = mdl[w][idx];
        end
        if (!keep) begin
            if (w == 0) ce2 = 1'b0; else ce1 = 1'b0;
        end
    endtask

    task automatic random_phase(input int w, input int n);
        bit prev_keep = 1'b0;
        for (int k = 0; k < n; k++) begin
            int          idx  = 64 + int'($urandom_range(0, 7));
            logic [31:0] a    = ($urandom & 32'hFFFF_F000) | 32'(idx << 2) | 32'($urandom_range(0, 3));
            bit          wr   = ($urandom_range(0, 1) == 1) || !vld[w][idx];
            bit          keep = (k != n - 1) && ($urandom_range(0, 1) == 1);
            access(w, wr, a, $urandom, 4'($urandom), keep, prev_keep);
            prev_keep = keep;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; ce2 = 1'b0; ce1 = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; sel = '0;
        last_rd[0] = '0; last_rd[1] = '0;
        last_done[0] = 0; last_done[1] = 0;
        repeat (3) @(negedge clk);
        check("rst_rdata2", rd2, 32'h0);
        check("rst_stall2", 32'(st2), 32'd0);
        check("rst_done2",  32'(dn2), 32'd0);
        check("rst_rdata1", rd1, 32'h0);
        rst_n = 1'b1;

        // Basic word write then read.
        access(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b0);
        access(0, 1'b0, 32'h0000_0010, 32'h0,         4'b0000, 1'b0, 1'b0);
        check("lw_deadbeef", rd2, 32'hDEAD_BEEF);

        // Byte and halfword lane merges.
        access(0, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1111, 1'b0, 1'b0);
        access(0, 1'b1, 32'h0000_0020, 32'hAAAA_AAAA, 4'b0100, 1'b0, 1'b0);
        access(0, 1'b0, 32'h0000_0020, 32'h0,         4'b0000, 1'b0, 1'b0);
        check("sb_merge", rd2, 32'h11AA_3344);
        access(0, 1'b1, 32'h0000_0020, 32'h5555_5555, 4'b0011, 1'b0, 1'b0);
        access(0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b0);
        access(0, 1'b0, 32'h0000_0020, 32'h0,         4'b1111, 1'b0, 1'b0);
        check("sh_merge", rd2, 32'h11AA_5555);

        // Abort: flush during BUSY must not write or complete.
        access(0, 1'b1, 32'h0000_0030, 32'h0000_0000, 4'b1111, 1'b0, 1'b0);
        @(negedge clk);
        we = 1'b1; addr = 32'h0000_0030; wdata = 32'hCAFE_BABE; sel = 4'b1111; ce2 = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(st2), 32'd1);
        ce2 = 1'b0;
        @(negedge clk);
        check("abort_stall", 32'(st2), 32'd0);
        check("abort_done",  32'(dn2), 32'd0);
        check("abort_rhold", rd2, last_rd[0]);
        @(negedge clk);
        check("abort_done2", 32'(dn2), 32'd0);
        access(0, 1'b0, 32'h0000_0030, 32'h0, 4'b1111, 1'b0, 1'b0);
        check("abort_word", rd2, 32'h0000_0000);

        // Reset while a write is in BUSY.
        access(0, 1'b1, 32'h0000_0040, 32'h1234_5678, 4'b1111, 1'b0, 1'b0);
        access(0, 1'b0, 32'h0000_0010, 32'h0,         4'b1111, 1'b0, 1'b0);
        @(negedge clk);
        we = 1'b1; addr = 32'h0000_0040; wdata = 32'hFFFF_FFFF; sel = 4'b1111; ce2 = 1'b1;
        @(negedge clk);
        rst_n = 1'b0; ce2 = 1'b0;
        #1;
        check("mid_rst_rdata", rd2, 32'h0);
        check("mid_rst_stall", 32'(st2), 32'd0);
        check("mid_rst_done",  32'(dn2), 32'd0);
        last_rd[0] = '0; last_rd[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        access(0, 1'b0, 32'h0000_0040, 32'h0, 4'b1111, 1'b0, 1'b0);
        check("mid_rst_word", rd2, 32'h1234_5678);

        // Address aliasing beyond ADDR_W.
        access(0, 1'b1, 32'h0000_1004, 32'h0BAD_F00D, 4'b1111, 1'b0, 1'b0);
        access(0, 1'b0, 32'h0000_0004, 32'h0,         4'b1111, 1'b0, 1'b0);
        check("alias_word", rd2, 32'h0BAD_F00D);

        // Back-to-back reads with the enable held high.
        access(0, 1'b0, 32'h0000_0010, 32'h0, 4'b1111, 1'b1, 1'b0);
        access(0, 1'b0, 32'h0000_0020, 32'h0, 4'b1111, 1'b1, 1'b1);
        access(0, 1'b0, 32'h0000_0040, 32'h0, 4'b1111, 1'b1, 1'b1);
        access(0, 1'b0, 32'h0000_0004, 32'h0, 4'b1111, 1'b0, 1'b1);

        // LATENCY=1 instance: single stall cycle, aliasing, back-to-back.
        access(1, 1'b1, 32'h0000_0008, 32'hA5A5_0F0F, 4'b1111, 1'b0, 1'b0);
        access(1, 1'b1, 32'h0000_1008, 32'h7700_0000, 4'b1000, 1'b1, 1'b0);
        access(1, 1'b0, 32'h0000_0008, 32'h0,         4'b0000, 1'b0, 1'b1);
        check("l1_merge", rd1, 32'h77A5_0F0F);

        random_phase(0, 150);
        random_phase(1, 150);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
